traffic_phase_controller: RTL

Sequences the two-approach intersection (north–south, east–west) through green, yellow and all-red phases. Green time is adapted to demand using the debounced, level-valid vehicle sensors produced by the sensor input handlers. All timing is counted in external `tick` strobes, so the block is independent of clock frequency. It drives the lamp outputs directly and exposes the current phase for monitoring.

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/phase_timer.sv | 35 +++
 rtl/traffic_phase_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the two-approach intersection controller:
// phase codes, lamp encodings and the phase-to-lamp decode.
package traffic_pkg;

    typedef enum logic [2:0] {
        RED_TO_NS = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        RED_TO_EW = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } phase_e;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    // Any approach not explicitly served is red, illegal codes included.
    function automatic lamps_t decode_lamps(input phase_e ph);
        lamps_t l;
        l.ns = LAMP_RED;
        l.ew = LAMP_RED;
        case (ph)
            NS_GREEN:  l.ns = LAMP_GREEN;
            NS_YELLOW: l.ns = LAMP_YELLOW;
            EW_GREEN:  l.ew = LAMP_GREEN;
            EW_YELLOW: l.ew = LAMP_YELLOW;
            default:   ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter: cleared on phase entry, advanced on tick,
// saturating at max_i. Exposes e = cnt + 1 for the phase decisions.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] max_i,
    output logic [CNT_W:0]   e_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign e_o = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = (e_o >= {1'b0, max_i}) ? max_i : e_o[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Demand-adaptive NS/EW phase sequencer with registered lamp outputs,
// timed entirely in external tick strobes.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ns_sensor,
    input  logic       ew_sensor,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase,
    output logic       phase_start
);

    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || YELLOW < 1 ||
        ALL_RED < 1 || MAX_GREEN >= (1 << CNT_W) ||
        YELLOW >= (1 << CNT_W) || ALL_RED >= (1 << CNT_W)) begin : g_bad_params
        $fatal(1, "traffic_phase_controller: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_C = CNT_W'(YELLOW);
    localparam logic [CNT_W-1:0] RED_C = CNT_W'(ALL_RED);
    localparam logic [CNT_W:0]   MAX_E = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0]   MIN_E = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0]   YEL_E = (CNT_W+1)'(YELLOW);
    localparam logic [CNT_W:0]   RED_E = (CNT_W+1)'(ALL_RED);

    phase_e           phase_q, phase_d;
    lamps_t           lamps_q, lamps_d;
    logic             start_q;
    logic             adv;
    logic [CNT_W-1:0] tmax;
    logic [CNT_W:0]   e;
    logic             ns_go, ew_go;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (adv),
        .tick_i (tick),
        .max_i  (tmax),
        .e_o    (e)
    );

    // Green ends only with cross demand: max-out, or gap-out past minimum.
    assign ns_go = ew_sensor && (e >= MAX_E || (e >= MIN_E && !ns_sensor));
    assign ew_go = ns_sensor && (e >= MAX_E || (e >= MIN_E && !ew_sensor));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= RED_TO_NS;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        adv     = 1'b0;
        tmax    = MAX_C;
        case (phase_q)
            RED_TO_NS: begin
                tmax = RED_C;
                if (tick && e >= RED_E) begin
                    adv     = 1'b1;
                    phase_d = NS_GREEN;
                end
            end
            NS_GREEN: begin
                if (tick && ns_go) begin
                    adv     = 1'b1;
                    phase_d = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                tmax = YEL_C;
                if (tick && e >= YEL_E) begin
                    adv     = 1'b1;
                    phase_d = RED_TO_EW;
                end
            end
            RED_TO_EW: begin
                tmax = RED_C;
                if (tick && e >= RED_E) begin
                    adv     = 1'b1;
                    phase_d = EW_GREEN;
                end
            end
            EW_GREEN: begin
                if (tick && ew_go) begin
                    adv     = 1'b1;
                    phase_d = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                tmax = YEL_C;
                if (tick && e >= YEL_E) begin
                    adv     = 1'b1;
                    phase_d = RED_TO_NS;
                end
            end
            default: begin
                adv     = 1'b1;
                phase_d = RED_TO_NS;
            end
        endcase
    end

    always_comb begin
        lamps_d = decode_lamps(phase_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamps_q <= '{ns: LAMP_RED, ew: LAMP_RED};
            start_q <= 1'b0;
        end else begin
            lamps_q <= lamps_d;
            start_q <= adv;
        end
    end

    assign phase       = phase_q;
    assign ns_light    = lamps_q.ns;
    assign ew_light    = lamps_q.ew;
    assign phase_start = start_q;

endmodule
